// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared fetch-path definitions: word width, next-PC opcodes, reset/exception vectors.
// Pure declarations; no timing or flow-control behaviour lives here.
package pc_fetch_ctrl_pkg;

  localparam int WORD_WIDTH = 32;
  localparam int NPC_OP_W   = 2;

  localparam logic [WORD_WIDTH-1:0] DEF_RESET_PC   = 32'h0000_3000;
  localparam logic [WORD_WIDTH-1:0] DEF_EXC_VECTOR = 32'h0000_4180;

  typedef enum logic [NPC_OP_W-1:0] {
    NPC_SEQ    = 2'd0,
    NPC_OFFSET = 2'd1,
    NPC_JUMP   = 2'd2
  } npc_op_t;

  // Fetched-instruction output register contents
  typedef struct packed {
    logic [WORD_WIDTH-1:0] pc;
    logic [WORD_WIDTH-1:0] instr;
  } fetch_t;

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-controller bundle: decode redirect, late flush, imem request/response, fetch output.
// fetch_exc exists only when FETCH_ALIGN_CHECK_EN is defined.
interface pc_fetch_ctrl_if;
  import pc_fetch_ctrl_pkg::*;

  logic                  br_valid;
  npc_op_t               br_op;
  logic [WORD_WIDTH-1:0] br_pc;
  logic [15:0]           br_imm16;
  logic [25:0]           br_imm26;
  logic                  flush_valid;
  logic [WORD_WIDTH-1:0] flush_target;
  logic                  imem_req;
  logic [WORD_WIDTH-1:0] imem_addr;
  logic                  imem_ack;
  logic [WORD_WIDTH-1:0] imem_rdata;
  logic                  if_valid;
  logic [WORD_WIDTH-1:0] if_pc;
  logic [WORD_WIDTH-1:0] if_instr;
  logic                  id_ready;
`ifdef FETCH_ALIGN_CHECK_EN
  logic                  fetch_exc;
`endif

  modport master (
    input  br_valid, br_op, br_pc, br_imm16, br_imm26,
    input  flush_valid, flush_target,
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output if_valid, if_pc, if_instr,
    input  id_ready
`ifdef FETCH_ALIGN_CHECK_EN
    , output fetch_exc
`endif
  );

  modport slave (
    output br_valid, br_op, br_pc, br_imm16, br_imm26,
    output flush_valid, flush_target,
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  if_valid, if_pc, if_instr,
    output id_ready
`ifdef FETCH_ALIGN_CHECK_EN
    , input fetch_exc
`endif
  );

endinterface

// File: rtl/pc_fetch_ctrl_npc.sv
// Next-PC adder: sequential, PC-relative offset, or region jump target.
// Purely combinational, no flow control.
module pc_fetch_ctrl_npc
  import pc_fetch_ctrl_pkg::*;
(
  input  logic [WORD_WIDTH-1:0] pc,
  input  npc_op_t               op,
  input  logic [15:0]           imm16,
  input  logic [25:0]           imm26,
  output logic [WORD_WIDTH-1:0] npc
);

  logic [WORD_WIDTH-1:0] pc_plus4;

  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    npc = pc_plus4;
    case (op)
      NPC_JUMP:   npc = {pc_plus4[31:28], imm26, 2'b00};
      NPC_OFFSET: npc = pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00};
      default:    npc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Instruction fetch controller: one outstanding imem request, redirect on flush/branch, 1-entry output hold.
// Optional FETCH_ALIGN_CHECK_EN traps misaligned targets to EXC_VECTOR; decode stalls hold the output register.
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter logic [WORD_WIDTH-1:0] RESET_PC   = DEF_RESET_PC,
  parameter logic [WORD_WIDTH-1:0] EXC_VECTOR = DEF_EXC_VECTOR
)
(
  input  logic           clk,
  input  logic           rst,
  pc_fetch_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [WORD_WIDTH-1:0] pc_q, pc_inc, npc_tgt, pc_cand, pc_new;
  logic                  pc_load, redirect, accept;
  fetch_t                if_q;

  pc_fetch_ctrl_npc u_npc (
    .pc    (bus.br_pc),
    .op    (bus.br_op),
    .imm16 (bus.br_imm16),
    .imm26 (bus.br_imm26),
    .npc   (npc_tgt)
  );

  assign pc_inc   = pc_q + 32'd4;
  assign redirect = bus.flush_valid || bus.br_valid;
  // A redirect in the ack cycle kills the returning instruction
  assign accept   = (state_q == REQ) && bus.imem_ack && !redirect;

  always_comb begin
    pc_load = 1'b0;
    pc_cand = pc_inc;
    if (state_q != BOOT) begin
      if (bus.flush_valid) begin
        pc_load = 1'b1;
        pc_cand = bus.flush_target;
      end else if (bus.br_valid) begin
        pc_load = 1'b1;
        pc_cand = npc_tgt;
      end else if (state_q == REQ && bus.imem_ack) begin
        pc_load = 1'b1;
        pc_cand = pc_inc;
      end
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  logic misalign;
  logic fetch_exc_q;

  assign misalign      = pc_load && (pc_cand[1:0] != 2'b00);
  assign pc_new        = misalign ? EXC_VECTOR : pc_cand;
  assign bus.imem_addr = pc_q;
  assign bus.fetch_exc = fetch_exc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fetch_exc_q <= 1'b0;
    else     fetch_exc_q <= misalign;
  end
`else
  assign pc_new        = pc_cand;
  assign bus.imem_addr = {pc_q[31:2], 2'b00};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
      if_q <= '0;
    end else begin
      if (pc_load) pc_q <= pc_new;
      if (accept)  if_q <= '{pc: pc_q, instr: bus.imem_rdata};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= BOOT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = REQ;
      REQ:     if (accept) state_d = HOLD;
      HOLD:    if (bus.flush_valid || bus.id_ready) state_d = REQ;
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    bus.imem_req = (state_q == REQ);
    bus.if_valid = (state_q == HOLD);
  end

  assign bus.if_pc    = if_q.pc;
  assign bus.if_instr = if_q.instr;

endmodule
